// File: rtl/frog_move_scheduler.sv
// Queues directional key presses and offers them one at a time to frog_pos over
// valid/ready. Each accepted move is followed by a fixed cooldown.
module frog_move_scheduler #(
  parameter int FIFO_DEPTH      = 4,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [3:0]                        press,
  input  logic                              move_ready,
  output logic                              move_valid,
  output logic [1:0]                        move_dir,
  output logic                              dropped,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending
);
  localparam int PW = $clog2(FIFO_DEPTH+1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_COOLDOWN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [PW-1:0]   count;

  logic            pop, has_press, multi, full, wr_ok, drop_nxt;
  logic [1:0]      win;

  assign pop       = (state == S_OFFER) && move_ready;
  assign has_press = |press;
  assign multi     = (press & (press - 4'd1)) != 4'd0;
  assign full      = count == PW'(FIFO_DEPTH);
  assign wr_ok     = has_press && (!full || pop);
  assign drop_nxt  = has_press && (multi || !wr_ok);

  // Fixed priority: lowest set bit wins (UP > DOWN > LEFT > RIGHT).
  always_comb begin
    win = 2'd0;
    casez (press)
      4'b???1: win = 2'd0;
      4'b??10: win = 2'd1;
      4'b?100: win = 2'd2;
      4'b1000: win = 2'd3;
      default: win = 2'd0;
    endcase
  end

  assign move_valid = state == S_OFFER;
  assign move_dir   = move_valid ? mem[rd_ptr] : 2'd0;
  assign pending    = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE:     if (count != '0) state_nxt = S_OFFER;
      S_OFFER:    if (pop) begin
                    state_nxt = S_COOLDOWN;
                    cnt_nxt   = CW'(COOLDOWN_CYCLES - 1);
                  end
      S_COOLDOWN: if (cnt == '0) state_nxt = S_IDLE;
                  else           cnt_nxt   = cnt - CW'(1);
      default:    state_nxt = S_IDLE;
    endcase
    // Disabling gameplay abandons whatever was in flight.
    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= drop_nxt;
      if (wr_ok) begin
        mem[wr_ptr] <= win;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + PW'(wr_ok) - PW'(pop);
    end
  end
endmodule
